// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit geometry and the hex glyph table.
package seg_pkg;

  localparam int unsigned NDIGITS = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Active-low gfedcba glyphs, entry k is the pattern for hex digit k.
  localparam logic [15:0][6:0] HEX7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_hex7.sv
// Combinational nibble to active-low seven-segment (gfedcba) decoder.
module seg_hex7
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [6:0]       seg_c_o
);

  assign seg_c_o = HEX7_LUT[nib_i];

endmodule

// File: rtl/seg_scan.sv
// Double-buffered 8-digit multiplexed seven-segment scanner with frame-aligned commit.
// Optional build macro SEG_BLANK_LEADING_ZEROS_EN blanks digits above the leading nonzero nibble.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIV = 2500
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [NDIGITS*NIB_W-1:0] i_data,
  input  logic [NDIGITS-1:0]       i_dp,
  output logic [NDIGITS-1:0]       o_ctl,
  output logic [SEG_W-1:0]         o_disp,
  output logic                     o_pending,
  output logic                     o_frame
);

  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned DATA_W = NDIGITS * NIB_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic [NDIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DATA_W-1:0]  disp_q, disp_d;
  logic [NDIGITS-1:0] disp_dp_q, disp_dp_d;
  logic               pending_q, pending_d;
  logic [NDIGITS-1:0] ctl_q, ctl_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               frame_q, frame_d;

  logic               slot_end_c;
  logic               commit_c;
  logic               blank_c;
  logic [NIB_W-1:0]   nib_c;
  logic [6:0]         glyph_c;

  seg_hex7 u_hex7 (
    .nib_i   (nib_c),
    .seg_c_o (glyph_c)
  );

  // Digit currently addressed by the scan, and whether it is a suppressed leading zero.
  always_comb begin
    nib_c = disp_q[{idx_q, 2'b00} +: NIB_W];
`ifdef SEG_BLANK_LEADING_ZEROS_EN
    blank_c = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
    blank_c = 1'b0;
`endif
  end

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    ctl_d       = SEG_BLANK;
    seg_d       = SEG_BLANK;
    frame_d     = 1'b0;

    slot_end_c = (cnt_q == CNT_MAX);
    commit_c   = slot_end_c && (idx_q == IDX_LAST);

    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end

    // Commit reads the old shadow; a same-cycle write refills it and keeps pending set.
    if (commit_c) begin
      frame_d   = 1'b1;
      pending_d = 1'b0;
      if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
    end

    if (i_we) begin
      shadow_d    = i_data;
      shadow_dp_d = i_dp;
      pending_d   = 1'b1;
    end

    // First cycle of each slot keeps every digit dark to avoid ghosting.
    if (cnt_q != '0) begin
      ctl_d = ~(NDIGITS'(1) << idx_q);
    end

    if (!blank_c) begin
      seg_d = {~disp_dp_q[idx_q], glyph_c};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      ctl_q       <= SEG_BLANK;
      seg_q       <= SEG_BLANK;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      ctl_q       <= ctl_d;
      seg_q       <= seg_d;
      frame_q     <= frame_d;
    end
  end

  assign o_ctl     = ctl_q;
  assign o_disp    = seg_q;
  assign o_pending = pending_q;
  assign o_frame   = frame_q;

endmodule
